wb_port_arbiter: RTL and testbench
==================================

# wb_port_arbiter

Arbitrates the register bank's single write port (WE/RDwb/WBd) between the memory-load, ALU and branch/kernel writeback sources. It also keeps a 16-entry pending-write scoreboard that stalls decode on RAW/WAW hazards. Sits between the execute/memory stages and the instruction decoder's register bank. The write port is registered, so a granted write lands in the bank one cycle after acceptance.

## Interface
Parameters:
- bus, 32, data width of writeback data
- NREQ, 3, number of writeback requesters (index 0 = MEM, 1 = ALU, 2 = BRANCH/KERNEL)
- PC_IDX, 4'b1110, register index of the PC; never tracked by the scoreboard

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  NREQ  requester i holds a write
- req_rd  in  NREQ×4  destination register per requester
- req_data  in  NREQ×bus  writeback data per requester
- req_ready  out  NREQ  one-hot grant; the write is accepted when valid & ready
- we_o  out  1  register bank write enable (WE)
- rd_wb_o  out  4  register bank write address (RDwb)
- wbd_o  out  bus  register bank write data (WBd)
- issue_valid  in  1  decode issues an instruction this cycle
- issue_wb  in  1  the issued instruction writes back (selWB)
- issue_rd  in  4  its destination register
- src_rs, src_rx  in  4 each  source register indices of the instruction in decode
- use_rs, use_rx  in  1 each  source is actually read
- stall_o  out  1  decode must hold; issue_valid is ignored while high

## Operation
- Arbitration is combinational on req_valid.
  - At most one req_ready bit is high.
  - Zero bits are high when no request is valid.
- Requesters must hold valid, rd and data stable until accepted.
  - Dropping valid before acceptance is illegal.
- An accepted request registers {1, rd, data} into {we_o, rd_wb_o, wbd_o} at the next edge.
  - With no acceptance, we_o goes 0 at that edge and rd_wb_o/wbd_o hold their values.
- Scoreboard `busy[15:0]`:
  - Set: busy[issue_rd] is set at the edge when issue_valid & issue_wb & ~stall_o & issue_rd≠PC_IDX.
  - Clear: busy[req_rd[g]] is cleared at the edge when grant g is accepted.
  - Set and clear of the same index at the same edge: set wins, because the new producer is outstanding.
- stall_o = issue_valid & ((use_rs & busy[src_rs]) | (use_rx & busy[src_rx]) | (issue_wb & busy[issue_rd])).
  - stall_o is purely combinational from registered state.
- A write to a register not marked busy is legal and leaves busy unchanged.
- Reset values:
  - we_o=0, rd_wb_o=0, wbd_o=0, busy=0.
  - Round-robin pointer = NREQ−1, so requester 0 has first priority.
  - req_ready=0 and stall_o=0 follow from the reset state.
- Reset asserted mid-operation: pending writes are discarded and the scoreboard cleared. Requesters must re-present after reset.

## Timing
- Request to accept: 0 cycles when granted in the same cycle.
- Accept to we_o: 1 cycle.
- A scoreboard clear takes effect on stall_o in the cycle after acceptance.
  - The bank write lands at the same edge, so a consumer un-stalled then reads fresh data through the bank.
- Throughput: one write per cycle.
- Starvation bound with round-robin: NREQ−1 cycles.

## Configuration
- Macro WBARB_RR_EN.
- Defined: round-robin arbitration.
  - The search starts at last_grant+1 mod NREQ.
  - last_grant updates only on acceptance.
- Undefined: fixed priority MEM > ALU > BRANCH.
  - No pointer register exists.
  - Starvation of lower indices is permitted.

## Structure
- Shared package `wb_pkg` holds:
  - requester index constants WB_MEM=0, WB_ALU=1, WB_BR=2;
  - REG_COUNT=16;
  - the PC_IDX default.
- One sub-module, `rr_arbiter`:
  - Parameterized on NREQ.
  - Inputs: request vector, pointer.
  - Output: one-hot grant.
  - Under `ifndef WBARB_RR_EN` it degenerates to a priority encoder.

## Test plan
- Reset: assert rst_n=0 mid-stream with busy=16'h0030 → all outputs 0 and busy=0 immediately (asynchronous); first cycle after release, a lone ALU request gets ready.
- Single write: ALU valid, rd=5, data=32'hDEADBEEF → req_ready=3'b010 same cycle; next cycle we_o=1, rd_wb_o=5, wbd_o=DEADBEEF; following cycle we_o=0.
- Contention, RR_EN defined: all three valid for 3 cycles → grants 001, 010, 100. Macro undefined: MEM granted 3 times while ALU/BR wait with ready=0.
- RAW stall: issue rd=3 → next cycle decode with use_rs, src_rs=3 gives stall_o=1; ALU write of r3 accepted at cycle k → stall_o=0 at k+1.
- Set/clear collision: same cycle ALU write of r7 accepted and new issue to r7 → busy[7]=1 afterwards, stall persists until the second r7 write.
- PC index: issue with issue_rd=14 → busy stays 0, no stall; branch write to r14 → we_o=1, rd_wb_o=14 next cycle.

Source files
------------

// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared constants for the writeback port arbiter
// Purpose: requester indices, register-file size and the PC register index
//          used by wb_port_arbiter and its testbench.
// Ports:   none (package).
package wb_pkg;

  // Requester slots on the writeback port, lowest index has fixed priority.
  localparam int WB_MEM = 0;
  localparam int WB_ALU = 1;
  localparam int WB_BR  = 2;

  localparam int REG_COUNT = 16;

  // The PC is written by the branch unit but never tracked as pending.
  localparam logic [3:0] PC_IDX_DEFAULT = 4'b1110;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - one-hot grant selection for the writeback requesters
// Purpose: picks one requester per cycle. With WBARB_RR_EN defined the search
//          starts one past the last granted index; otherwise the lowest
//          requesting index wins and ptr is ignored.
// Ports:   req   - request vector (NREQ)
//          ptr   - index of the last accepted requester (PW)
//          grant - one-hot grant, all zero when nothing requests (NREQ)
module rr_arbiter #(
  parameter int NREQ = 3,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] grant
);

`ifdef WBARB_RR_EN
  // Unrolled per pointer value so every index stays a constant.
  always_comb begin
    logic found;
    grant = '0;
    found = 1'b0;
    for (int p = 0; p < NREQ; p++) begin
      if (ptr == PW'(p)) begin
        for (int off = 1; off <= NREQ; off++) begin
          if (!found && req[(p + off) % NREQ]) begin
            grant[(p + off) % NREQ] = 1'b1;
            found = 1'b1;
          end
        end
      end
    end
  end
`else
  logic unused_ptr;
  assign unused_ptr = ^ptr;

  always_comb begin
    logic found;
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req[i]) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - register bank write-port arbiter with hazard scoreboard
// Purpose: shares the bank's single registered write port between MEM, ALU
//          and BRANCH/KERNEL writebacks, and tracks pending destination
//          registers so decode stalls on RAW/WAW hazards.
//          Macro WBARB_RR_EN: defined = round-robin, undefined = fixed
//          priority MEM > ALU > BRANCH.
// Ports:   clk, rst_n                - clock, asynchronous active-low reset
//          req_valid/req_rd/req_data - per-requester write (flattened vectors)
//          req_ready                 - one-hot grant, accept = valid & ready
//          we_o/rd_wb_o/wbd_o        - registered bank write port
//          issue_valid/issue_wb/issue_rd - instruction issued by decode
//          src_rs/src_rx/use_rs/use_rx   - sources read by decode
//          stall_o                   - decode must hold
module wb_port_arbiter
  import wb_pkg::*;
#(
  parameter int         bus    = 32,
  parameter int         NREQ   = 3,
  parameter logic [3:0] PC_IDX = PC_IDX_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*4-1:0] req_rd,
  input  logic [NREQ*bus-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic              we_o,
  output logic [3:0]        rd_wb_o,
  output logic [bus-1:0]    wbd_o,
  input  logic              issue_valid,
  input  logic              issue_wb,
  input  logic [3:0]        issue_rd,
  input  logic [3:0]        src_rs,
  input  logic [3:0]        src_rx,
  input  logic              use_rs,
  input  logic              use_rx,
  output logic              stall_o
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]      grant;
  logic [PW-1:0]        ptr;
  logic                 accept;
  logic [3:0]           sel_rd;
  logic [bus-1:0]       sel_data;
  logic [REG_COUNT-1:0] busy;
  logic [REG_COUNT-1:0] busy_nxt;
  logic                 do_set;

  rr_arbiter #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_arb (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (grant)
  );

  assign req_ready = grant;
  assign accept    = |(grant & req_valid);

  // Grant is one-hot, so an OR-mux selects the winner's rd/data.
  always_comb begin
    sel_rd   = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_rd   = sel_rd | req_rd[i*4 +: 4];
        sel_data = sel_data | req_data[i*bus +: bus];
      end
    end
  end

`ifdef WBARB_RR_EN
  logic [PW-1:0] sel_idx;

  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) sel_idx = sel_idx | PW'(i);
    end
  end

  // Reset to NREQ-1 so the first search begins at requester 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= PW'(NREQ - 1);
    end else if (accept) begin
      ptr <= sel_idx;
    end
  end
`else
  assign ptr = '0;
`endif

  // Registered bank write port; address/data hold when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_o    <= 1'b0;
      rd_wb_o <= '0;
      wbd_o   <= '0;
    end else begin
      we_o <= accept;
      if (accept) begin
        rd_wb_o <= sel_rd;
        wbd_o   <= sel_data;
      end
    end
  end

  assign stall_o = issue_valid & ((use_rs & busy[src_rs]) |
                                  (use_rx & busy[src_rx]) |
                                  (issue_wb & busy[issue_rd]));

  assign do_set = issue_valid & issue_wb & ~stall_o & (issue_rd != PC_IDX);

  // Set is applied after clear: a freshly issued producer stays outstanding
  // even when an older write of the same register retires this edge.
  always_comb begin
    busy_nxt = busy;
    if (accept) busy_nxt[sel_rd]   = 1'b0;
    if (do_set) busy_nxt[issue_rd] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb/tb_wb_port_arbiter.sv - scoreboard testbench for wb_port_arbiter
module tb_wb_port_arbiter;
  import wb_pkg::*;

  localparam int BUS  = 32;
  localparam int NREQ = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*4-1:0] req_rd;
  logic [NREQ*BUS-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic              we_o;
  logic [3:0]        rd_wb_o;
  logic [BUS-1:0]    wbd_o;
  logic              issue_valid, issue_wb, use_rs, use_rx;
  logic [3:0]        issue_rd, src_rs, src_rx;
  logic              stall_o;

  wb_port_arbiter #(.bus(BUS), .NREQ(NREQ), .PC_IDX(PC_IDX_DEFAULT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_rd(req_rd), .req_data(req_data),
    .req_ready(req_ready),
    .we_o(we_o), .rd_wb_o(rd_wb_o), .wbd_o(wbd_o),
    .issue_valid(issue_valid), .issue_wb(issue_wb), .issue_rd(issue_rd),
    .src_rs(src_rs), .src_rx(src_rx), .use_rs(use_rs), .use_rx(use_rx),
    .stall_o(stall_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  rd;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  n_tests = 0;
  int  n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [3:0] rd, input logic [31:0] d);
    req_valid[i]         = v;
    req_rd[i*4 +: 4]     = rd;
    req_data[i*BUS +: BUS] = d;
  endtask

  task automatic clear_reqs();
    req_valid = '0;
    req_rd    = '0;
    req_data  = '0;
  endtask

  task automatic idle_issue();
    issue_valid = 1'b0; issue_wb = 1'b0; issue_rd = '0;
    use_rs = 1'b0; use_rx = 1'b0; src_rs = '0; src_rx = '0;
  endtask

  task automatic do_issue(input logic [3:0] rd);
    idle_issue();
    issue_valid = 1'b1; issue_wb = 1'b1; issue_rd = rd;
  endtask

  // Side-effect-free look at busy[r]: a non-writing instruction reading r.
  task automatic probe_rs(input string name, input logic [3:0] r, input logic exp);
    idle_issue();
    issue_valid = 1'b1; use_rs = 1'b1; src_rs = r;
    #1;
    chk(name, 32'(stall_o), 32'(exp));
  endtask

  task automatic expect_wr(input logic [3:0] rd, input logic [31:0] d);
    wr_t e;
    e.rd = rd;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_reqs();
    idle_issue();
    step();
    step();
    exp_q.delete();
    rst_n = 1'b1;
  endtask

  // Monitor: every bank write must match the next expected write.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (rst_n && we_o) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL wr_unexpected: got rd=%0d data=%0h expected no write", rd_wb_o, wbd_o);
        end else begin
          e = exp_q.pop_front();
          chk("wr_rd", 32'(rd_wb_o), 32'(e.rd));
          chk("wr_data", wbd_o, e.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  logic [2:0]  exp_g [3];
  logic [3:0]  rd_tab [3];
  logic [31:0] d_tab [3];

  initial begin
    clear_reqs();
    idle_issue();
    do_reset();

    // Reset state
    #1;
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_we", 32'(we_o), 32'h0);
    chk("rst_rd", 32'(rd_wb_o), 32'h0);
    chk("rst_wbd", wbd_o, 32'h0);
    probe_rs("rst_busy_r0", 4'd0, 1'b0);
    idle_issue();

    // Build busy=0x0030 plus a held write port, then reset mid-cycle
    set_req(WB_ALU, 1'b1, 4'd9, 32'h11);
    do_issue(4'd4);
    #1;
    chk("pre_ready", 32'(req_ready), 32'h2);
    chk("pre_stall", 32'(stall_o), 32'h0);
    expect_wr(4'd9, 32'h11);
    step();
    set_req(WB_ALU, 1'b0, 4'd0, 32'h0);
    do_issue(4'd5);
    #1;
    chk("pre_stall2", 32'(stall_o), 32'h0);
    step();
    probe_rs("busy_r4", 4'd4, 1'b1);
    idle_issue();
    issue_valid = 1'b1; use_rx = 1'b1; src_rx = 4'd5;
    #1;
    chk("busy_r5_rx", 32'(stall_o), 32'h1);
    chk("held_rd", 32'(rd_wb_o), 32'd9);
    rst_n = 1'b0;
    #1;
    chk("async_we", 32'(we_o), 32'h0);
    chk("async_rd", 32'(rd_wb_o), 32'h0);
    chk("async_wbd", wbd_o, 32'h0);
    chk("async_busy", 32'(stall_o), 32'h0);
    idle_issue();
    step();
    rst_n = 1'b1;
    set_req(WB_ALU, 1'b1, 4'd2, 32'h22);
    #1;
    chk("post_rst_ready", 32'(req_ready), 32'h2);
    expect_wr(4'd2, 32'h22);
    step();
    clear_reqs();

    // Single write
    set_req(WB_ALU, 1'b1, 4'd5, 32'hDEADBEEF);
    #1;
    chk("single_ready", 32'(req_ready), 32'h2);
    expect_wr(4'd5, 32'hDEADBEEF);
    step();
    clear_reqs();
    #1;
    chk("single_we", 32'(we_o), 32'h1);
    chk("single_rd", 32'(rd_wb_o), 32'd5);
    chk("single_wbd", wbd_o, 32'hDEADBEEF);
    step();
    chk("single_we_off", 32'(we_o), 32'h0);
    chk("single_rd_hold", 32'(rd_wb_o), 32'd5);
    chk("single_wbd_hold", wbd_o, 32'hDEADBEEF);

    // Contention from a fresh pointer
    do_reset();
    rd_tab[0] = 4'd1; d_tab[0] = 32'hA1;
    rd_tab[1] = 4'd2; d_tab[1] = 32'hA2;
    rd_tab[2] = 4'd3; d_tab[2] = 32'hA3;
`ifdef WBARB_RR_EN
    exp_g[0] = 3'b001; exp_g[1] = 3'b010; exp_g[2] = 3'b100;
`else
    exp_g[0] = 3'b001; exp_g[1] = 3'b001; exp_g[2] = 3'b001;
`endif
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, rd_tab[i], d_tab[i]);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("contend_%0d", c), 32'(req_ready), 32'(exp_g[c]));
      for (int i = 0; i < NREQ; i++) begin
        if (exp_g[c][i]) expect_wr(rd_tab[i], d_tab[i]);
      end
      step();
    end
    set_req(WB_MEM, 1'b0, 4'd0, 32'h0);
    #1;
    chk("contend_no_mem", 32'(req_ready), 32'h2);
    expect_wr(rd_tab[1], d_tab[1]);
    step();
    clear_reqs();

    // RAW stall and release
    do_issue(4'd3);
    #1;
    chk("raw_issue", 32'(stall_o), 32'h0);
    step();
    do_issue(4'd8);
    use_rs = 1'b1; src_rs = 4'd3;
    #1;
    chk("raw_stall", 32'(stall_o), 32'h1);
    step();
    chk("raw_stall_hold", 32'(stall_o), 32'h1);
    set_req(WB_ALU, 1'b1, 4'd3, 32'h33);
    #1;
    chk("raw_wr_ready", 32'(req_ready), 32'h2);
    chk("raw_stall_k", 32'(stall_o), 32'h1);
    expect_wr(4'd3, 32'h33);
    step();
    clear_reqs();
    probe_rs("raw_release", 4'd3, 1'b0);
    probe_rs("no_set_while_stalled", 4'd8, 1'b0);
    idle_issue();

    // Set/clear collision on r7
    set_req(WB_ALU, 1'b1, 4'd7, 32'h77);
    do_issue(4'd7);
    #1;
    chk("coll_ready", 32'(req_ready), 32'h2);
    chk("coll_stall", 32'(stall_o), 32'h0);
    expect_wr(4'd7, 32'h77);
    step();
    clear_reqs();
    idle_issue();
    issue_valid = 1'b1; use_rx = 1'b1; src_rx = 4'd7;
    #1;
    chk("coll_set_wins", 32'(stall_o), 32'h1);
    step();
    chk("coll_persist", 32'(stall_o), 32'h1);
    set_req(WB_ALU, 1'b1, 4'd7, 32'h78);
    #1;
    chk("coll_wr2_ready", 32'(req_ready), 32'h2);
    expect_wr(4'd7, 32'h78);
    step();
    clear_reqs();
    chk("coll_release", 32'(stall_o), 32'h0);
    idle_issue();

    // PC index is never tracked
    do_issue(PC_IDX_DEFAULT);
    #1;
    chk("pc_issue", 32'(stall_o), 32'h0);
    step();
    do_issue(PC_IDX_DEFAULT);
    use_rs = 1'b1; src_rs = PC_IDX_DEFAULT;
    #1;
    chk("pc_no_stall", 32'(stall_o), 32'h0);
    set_req(WB_BR, 1'b1, PC_IDX_DEFAULT, 32'hC0DE);
    #1;
    chk("pc_br_ready", 32'(req_ready), 32'h4);
    expect_wr(PC_IDX_DEFAULT, 32'hC0DE);
    step();
    clear_reqs();
    idle_issue();
    #1;
    chk("pc_we", 32'(we_o), 32'h1);
    chk("pc_rd", 32'(rd_wb_o), 32'(PC_IDX_DEFAULT));

    step();
    step();
    chk("queue_empty", 32'(exp_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
